// File: rtl/pressao_pkg.sv
// Shared constants and FSM state type for the pressure acquisition stage.
package pressao_pkg;

  localparam int unsigned LARGURA_PADRAO     = 4;
  localparam int unsigned MEDIA_LOG2_PADRAO  = 2;
  localparam int unsigned TIMEOUT_PADRAO     = 15;
  localparam int unsigned VALOR_FALHA_PADRAO = 0;

  localparam int unsigned NUM_CANAIS = 7;

  localparam logic [2:0] CANAL_SC    = 3'd0;
  localparam logic [2:0] CANAL_S1    = 3'd1;
  localparam logic [2:0] CANAL_S2    = 3'd2;
  localparam logic [2:0] CANAL_S3    = 3'd3;
  localparam logic [2:0] CANAL_TUBSR = 3'd4;
  localparam logic [2:0] CANAL_TUBSS = 3'd5;
  localparam logic [2:0] CANAL_REA   = 3'd6;

  typedef enum logic [1:0] {SOLICITA, LIBERA, AVANCA} estado_t;

endpackage

// File: rtl/handshake_adc.sv
// Four-phase req/ack sequencer for the shared ADC, with per-phase timeout.
module handshake_adc
  import pressao_pkg::*;
#(
  parameter int unsigned LARGURA        = LARGURA_PADRAO,
  parameter int unsigned TIMEOUT_CICLOS = TIMEOUT_PADRAO,
  parameter int unsigned VALOR_FALHA    = VALOR_FALHA_PADRAO
) (
  input  logic               clk,
  input  logic               reset,
  output logic               adcReq,
  input  logic               adcAck,
  input  logic [LARGURA-1:0] adcDado,
  output logic               amostraPronta,
  output logic [LARGURA-1:0] amostraValor,
  output logic               falhou,
  output logic               avanca
);

  localparam int unsigned TW = (TIMEOUT_CICLOS < 1) ? 1 : $clog2(TIMEOUT_CICLOS + 1);
  localparam logic [TW-1:0] LIMITE = TW'(TIMEOUT_CICLOS);

  estado_t       estado, estadoProx;
  logic [TW-1:0] timer;
  logic          esgotou;

  assign esgotou = (timer == LIMITE);

  always_ff @(posedge clk) begin
    if (reset) begin
      estado <= SOLICITA;
      timer  <= '0;
    end else begin
      estado <= estadoProx;
      if (estadoProx != estado)
        timer <= '0;
      else if (!esgotou)
        timer <= timer + 1'b1;
    end
  end

  always_comb begin
    estadoProx = estado;
    unique case (estado)
      SOLICITA: if (adcAck || esgotou) estadoProx = LIBERA;
      LIBERA:   if (!adcAck || esgotou) estadoProx = AVANCA;
      AVANCA:   estadoProx = SOLICITA;
      default:  estadoProx = SOLICITA;
    endcase
  end

  // adcReq is gated by reset so a request in flight drops on the reset edge
  always_comb begin
    adcReq        = 1'b0;
    amostraPronta = 1'b0;
    amostraValor  = LARGURA'(VALOR_FALHA);
    falhou        = 1'b0;
    avanca        = 1'b0;
    case (estado)
      SOLICITA: begin
        adcReq = !reset;
        if (adcAck) begin
          amostraPronta = 1'b1;
          amostraValor  = adcDado;
        end else if (esgotou) begin
          amostraPronta = 1'b1;
          falhou        = 1'b1;
        end
      end
      LIBERA:  falhou = adcAck && esgotou;
      AVANCA:  avanca = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: rtl/aquisicao_pressao.sv
// Scans seven pressure channels over one ADC, averages 2^MEDIA_LOG2 rounds
// and publishes registered pressures plus per-channel fault flags.
module aquisicao_pressao
  import pressao_pkg::*;
#(
  parameter int unsigned LARGURA        = LARGURA_PADRAO,
  parameter int unsigned MEDIA_LOG2     = MEDIA_LOG2_PADRAO,
  parameter int unsigned TIMEOUT_CICLOS = TIMEOUT_PADRAO,
  parameter int unsigned VALOR_FALHA    = VALOR_FALHA_PADRAO
) (
  input  logic               clk,
  input  logic               reset,
  output logic               adcReq,
  output logic [2:0]         adcCanal,
  input  logic               adcAck,
  input  logic [LARGURA-1:0] adcDado,
  output logic [LARGURA-1:0] sensPresSC,
  output logic [LARGURA-1:0] sensPresS1,
  output logic [LARGURA-1:0] sensPresS2,
  output logic [LARGURA-1:0] sensPresS3,
  output logic [LARGURA-1:0] sensPresTubSR,
  output logic [LARGURA-1:0] sensPresTubSS,
  output logic [LARGURA-1:0] sensPresRea,
  output logic               dadosValidos,
  output logic               atualiza,
  output logic [6:0]         falhaAdc
);

  localparam int unsigned AW = LARGURA + MEDIA_LOG2;

  logic [2:0]            canal;
  logic [MEDIA_LOG2-1:0] rodada;
  logic [AW-1:0]         acc  [NUM_CANAIS];
  logic [LARGURA-1:0]    pres [NUM_CANAIS];

  logic               amostraPronta;
  logic [LARGURA-1:0] amostraValor;
  logic               falhou;
  logic               avanca;

  handshake_adc #(
    .LARGURA        (LARGURA),
    .TIMEOUT_CICLOS (TIMEOUT_CICLOS),
    .VALOR_FALHA    (VALOR_FALHA)
  ) uHandshake (
    .clk           (clk),
    .reset         (reset),
    .adcReq        (adcReq),
    .adcAck        (adcAck),
    .adcDado       (adcDado),
    .amostraPronta (amostraPronta),
    .amostraValor  (amostraValor),
    .falhou        (falhou),
    .avanca        (avanca)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      canal        <= CANAL_SC;
      rodada       <= '0;
      dadosValidos <= 1'b0;
      atualiza     <= 1'b0;
      falhaAdc     <= '0;
      for (int unsigned i = 0; i < NUM_CANAIS; i++) begin
        acc[i]  <= '0;
        pres[i] <= '0;
      end
    end else begin
      atualiza <= 1'b0;
      if (amostraPronta)
        acc[canal] <= acc[canal] + AW'(amostraValor);
      if (falhou)
        falhaAdc[canal] <= 1'b1;
      else if (amostraPronta)
        falhaAdc[canal] <= 1'b0;
      // samples never arrive in AVANCA, so clearing accumulators here is race-free
      if (avanca) begin
        if (canal == CANAL_REA) begin
          canal  <= CANAL_SC;
          rodada <= rodada + 1'b1;
          if (rodada == '1) begin
            for (int unsigned i = 0; i < NUM_CANAIS; i++) begin
              pres[i] <= LARGURA'(acc[i] >> MEDIA_LOG2);
              acc[i]  <= '0;
            end
            atualiza     <= 1'b1;
            dadosValidos <= 1'b1;
          end
        end else begin
          canal <= canal + 3'd1;
        end
      end
    end
  end

  assign adcCanal      = canal;
  assign sensPresSC    = pres[CANAL_SC];
  assign sensPresS1    = pres[CANAL_S1];
  assign sensPresS2    = pres[CANAL_S2];
  assign sensPresS3    = pres[CANAL_S3];
  assign sensPresTubSR = pres[CANAL_TUBSR];
  assign sensPresTubSS = pres[CANAL_TUBSS];
  assign sensPresRea   = pres[CANAL_REA];

endmodule

// File: tb/tb_aquisicao_pressao.sv
// Randomized bench: a behavioural ADC follows a per-round plan; expected
// averages and fault flags are computed from that plan.
module tb_aquisicao_pressao;

  localparam int NC   = 7;
  localparam int MAXR = 32;
  localparam int VF   = 0;

  typedef enum int {OK, SEM_ACK, PRESO} modo_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       adcReq;
  logic [2:0] adcCanal;
  logic       adcAck;
  logic [3:0] adcDado;
  logic [3:0] sensPresSC, sensPresS1, sensPresS2, sensPresS3;
  logic [3:0] sensPresTubSR, sensPresTubSS, sensPresRea;
  logic       dadosValidos, atualiza;
  logic [6:0] falhaAdc;

  always #5 clk = ~clk;

  aquisicao_pressao #(
    .LARGURA        (4),
    .MEDIA_LOG2     (2),
    .TIMEOUT_CICLOS (15),
    .VALOR_FALHA    (VF)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .adcReq        (adcReq),
    .adcCanal      (adcCanal),
    .adcAck        (adcAck),
    .adcDado       (adcDado),
    .sensPresSC    (sensPresSC),
    .sensPresS1    (sensPresS1),
    .sensPresS2    (sensPresS2),
    .sensPresS3    (sensPresS3),
    .sensPresTubSR (sensPresTubSR),
    .sensPresTubSS (sensPresTubSS),
    .sensPresRea   (sensPresRea),
    .dadosValidos  (dadosValidos),
    .atualiza      (atualiza),
    .falhaAdc      (falhaAdc)
  );

  modo_t modo   [MAXR][NC];
  int    dado   [MAXR][NC];
  int    atraso [MAXR][NC];

  int nPass = 0;
  int nTotal = 0;
  int base = 0;
  int rod = -1;
  int expCanal = -1;
  int hi = 0;
  int lo = 0;
  logic prevReq = 1'b0;
  modo_t modoAtual = OK;
  logic [2:0] canalReq = '0;

  task automatic confere(input string tag, input int obs, input int esp);
    nTotal++;
    if (obs == esp) nPass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, esp, $time);
  endtask

  function automatic int saida(input int c);
    case (c)
      0: return int'(sensPresSC);
      1: return int'(sensPresS1);
      2: return int'(sensPresS2);
      3: return int'(sensPresS3);
      4: return int'(sensPresTubSR);
      5: return int'(sensPresTubSS);
      default: return int'(sensPresRea);
    endcase
  endfunction

  // Behavioural ADC: acks after the planned delay, never acks, or holds ack high
  always @(negedge clk) begin
    if (reset) begin
      adcAck    = 1'b0;
      adcDado   = '0;
      prevReq   = 1'b0;
      rod       = base - 1;
      expCanal  = -1;
      modoAtual = OK;
      hi        = 0;
      lo        = 0;
    end else begin
      if (adcReq && !prevReq) begin
        if (modoAtual == PRESO) confere("liberaMin", int'(lo >= 16), 1);
        expCanal = (expCanal + 1) % NC;
        if (expCanal == 0) rod++;
        confere("canalSeq", adcCanal, expCanal);
        canalReq  = adcCanal;
        modoAtual = modo[rod][expCanal];
        hi        = 0;
      end
      if (!adcReq && prevReq) begin
        confere($sformatf("falhaCanal%0d", canalReq), falhaAdc[canalReq], int'(modoAtual == SEM_ACK));
        if (modoAtual == SEM_ACK) confere("ciclosTimeout", hi, 16);
        lo = 0;
      end
      if (adcReq) begin
        hi++;
        confere("canalEstavel", adcCanal, canalReq);
        adcAck  = (modoAtual != SEM_ACK) && (hi >= atraso[rod][expCanal]);
        adcDado = 4'(dado[rod][expCanal]);
      end else begin
        lo++;
        if (!(modoAtual == PRESO && lo < 17)) adcAck = 1'b0;
      end
      prevReq = adcReq;
    end
  end

  task automatic esperaPub(output int n);
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!atualiza && n < 3000);
  endtask

  task automatic confPub(input int r0);
    int soma;
    confere("atualiza", atualiza, 1);
    for (int c = 0; c < NC; c++) begin
      soma = 0;
      for (int r = r0; r < r0 + 4; r++) soma += (modo[r][c] == SEM_ACK) ? VF : dado[r][c];
      confere($sformatf("pres%0d_r%0d", c, r0), saida(c), soma / 4);
      confere($sformatf("falhaPub%0d_r%0d", c, r0), falhaAdc[c], int'(modo[r0 + 3][c] != OK));
    end
    confere("dadosValidos", dadosValidos, 1);
    @(posedge clk); #1;
    confere("atualizaPulso", atualiza, 0);
  endtask

  task automatic confReset(input string tag);
    confere({tag, "_req"}, adcReq, 0);
    confere({tag, "_valid"}, dadosValidos, 0);
    confere({tag, "_atualiza"}, atualiza, 0);
    confere({tag, "_falha"}, falhaAdc, 0);
    for (int c = 0; c < NC; c++) confere($sformatf("%s_pres%0d", tag, c), saida(c), 0);
  endtask

  initial begin
    int n;
    int m;

    for (int r = 0; r < MAXR; r++) begin
      for (int c = 0; c < NC; c++) begin
        m = $urandom_range(0, 9);
        modo[r][c]   = (m < 7) ? OK : (m < 9) ? SEM_ACK : PRESO;
        dado[r][c]   = $urandom_range(0, 15);
        atraso[r][c] = (modo[r][c] == OK) ? $urandom_range(1, 16) : $urandom_range(1, 4);
      end
    end
    for (int r = 0; r < 8; r++) begin
      for (int c = 0; c < NC; c++) begin
        modo[r][c]   = OK;
        atraso[r][c] = 1;
        dado[r][c]   = (r < 4) ? c + 8 : 8;
      end
    end
    for (int r = 4; r < 8; r++) begin
      dado[r][3] = 9 + (r - 4);
      modo[r][5] = SEM_ACK;
    end
    modo[8][5]   = OK;
    atraso[8][5] = $urandom_range(1, 16);
    modo[9][2]   = OK;
    atraso[9][2] = 16;
    modo[10][4]  = PRESO;
    modo[11][4]  = OK;
    for (int r = 19; r < 23; r++) begin
      for (int c = 0; c < NC; c++) begin
        modo[r][c]   = OK;
        atraso[r][c] = 1;
      end
    end

    base  = 0;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    confReset("reset");
    reset = 1'b0;

    esperaPub(n);
    confere("ciclosPrimeiraPub", n, 84);
    confPub(0);
    esperaPub(n);
    confPub(4);
    esperaPub(n);
    confPub(8);
    esperaPub(n);
    confPub(12);

    n = 0;
    while (!(rod == 18 && expCanal == 3 && adcReq) && n < 3000) begin
      @(posedge clk); #1;
      n++;
    end
    confere("achouHandshake", int'(n < 3000), 1);
    base  = 19;
    reset = 1'b1;
    @(posedge clk); #1;
    confReset("resetMeio");
    @(posedge clk); #1;
    reset = 1'b0;

    esperaPub(n);
    confere("ciclosPubPosReset", n, 84);
    confPub(19);

    $display("%0d/%0d checks passed", nPass, nTotal);
    $finish;
  end

endmodule
